mc_ram_1p_ctrl: RTL and testbench
=================================

# mc_ram_1p_ctrl

Access controller on the requester side of a single-port motion-compensation SRAM (default 20x256). It sits between the MC datapath and the RAM's active-low cen/oen/wen/addr/data pins. It turns two independent streams into legal one-access-per-cycle RAM traffic:
- a burst-write channel with an auto-incrementing address;
- a random-access read channel with a response buffer and backpressure.

## Interface
Parameters:
- Word_Width, 20, RAM data width
- Addr_Width, 8, RAM address width (depth 2^Addr_Width)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rstn  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse: begin write burst
- base_i  in  Addr_Width  burst start address, sampled with start_i
- len_i  in  Addr_Width+1  burst length in beats (1..2^Addr_Width), sampled with start_i
- busy_o  out  1  burst in progress
- done_o  out  1  one-cycle pulse after the final burst beat is issued
- wr_val_i  in  1  write beat valid
- wr_dat_i  in  Word_Width  write beat data
- wr_rdy_o  out  1  write beat accepted when wr_val_i & wr_rdy_o
- rd_req_i  in  1  read request
- rd_addr_i  in  Addr_Width  read address
- rd_ack_o  out  1  request accepted when rd_req_i & rd_ack_o
- rd_val_o  out  1  read data valid
- rd_dat_o  out  Word_Width  read data
- rd_rdy_i  in  1  consumer ready; pop when rd_val_o & rd_rdy_i
- ram_cen_o  out  1  RAM chip enable, active-low
- ram_oen_o  out  1  RAM output enable, active-low; held 0 out of reset
- ram_wen_o  out  1  RAM write enable, 0 = write, 1 = read
- ram_addr_o  out  Addr_Width  RAM address
- ram_dat_o  out  Word_Width  RAM write data
- ram_dat_i  in  Word_Width  RAM read data, valid the cycle after a read access

## Operation
FSM states:
- IDLE → FILL on start_i with len_i != 0. Latch waddr = base_i and remaining = len_i.
- start_i with len_i == 0: ignored, no done_o.
- start_i while in FILL: ignored.

FILL behaviour:
- busy_o = 1.
- Each accepted write beat drives RAM write at waddr, then waddr increments modulo 2^Addr_Width (255 → 0) and remaining decrements.
- The beat taking remaining from 1 to 0 ends the burst: the FSM returns to IDLE and done_o pulses for exactly one cycle on the following cycle.

Arbitration (one RAM access per cycle):
- Write candidate: FILL & wr_val_i. Read candidate: rd_req_i & credit.
- Only one candidate present: it wins.
- Both present: the side holding the priority bit wins, then the bit toggles. After reset the bit favours write.
- wr_rdy_o = write wins; rd_ack_o = read wins. Both depend combinationally on same-cycle inputs.

RAM drive (combinational from the grant):
- Any grant: ram_cen_o = 0; otherwise ram_cen_o = 1.
- Write grant: ram_wen_o = 0; otherwise ram_wen_o = 1.
- ram_addr_o = waddr or rd_addr_i. ram_dat_o = wr_dat_i.
- RAM order equals grant order, so a read granted after a write to the same address returns the new data.

Read response:
- A 2-entry FIFO holds read data. An inflight flag marks a read granted in the previous cycle.
- Capture ram_dat_i into the FIFO in the cycle the inflight flag is set.
- credit = (occupancy + inflight − pop) < 2. This guarantees no overflow and allows 1 read/cycle when rd_rdy_i stays high.

## Timing
- Read latency: request accepted in cycle c → rd_val_o high in cycle c+2. Data holds while rd_rdy_i = 0.
- Write: beat accepted in cycle c → RAM samples it at the end of cycle c.
- done_o: the cycle after the last write beat.
- Reset values:
  - busy_o, done_o, wr_rdy_o, rd_ack_o, rd_val_o = 0.
  - rd_dat_o = 0, ram_cen_o = 1, ram_wen_o = 1, ram_oen_o = 0.
  - ram_addr_o = 0, ram_dat_o = 0.
  - FSM = IDLE, FIFO empty, inflight = 0, priority bit = write.
- Reset mid-operation: burst is abandoned with no done_o; any inflight read and buffered data are discarded.
- Simultaneous push and pop on the FIFO: occupancy unchanged, order preserved.

## Structure
- Shared package/defines: Word_Width/Addr_Width defaults and FSM state encodings (IDLE = 0, FILL = 1).
- One sub-module is natural: mc_rd_fifo2, a 2-entry synchronous FIFO with push/pop/count. The arbiter, FSM and RAM drive stay in the top level.
- The RAM itself is external: a ram_1p instance in the parent.

## Test plan
- Burst: start_i with base 0xFE, len 4, wr_val_i held high, data 1..4 → RAM writes at 0xFE, 0xFF, 0x00, 0x01. done_o pulses in the cycle after beat 4. busy_o falls with it.
- Read back: reads 0xFE..0x01 with rd_rdy_i = 1 → one ack per cycle; rd_dat_o = 1,2,3,4 in order, each 2 cycles after its ack.
- Contention: FILL with continuous wr_val_i and continuous rd_req_i → grants alternate W,R,W,R starting with W after reset. A read of the address just written returns the new value.
- Backpressure: rd_rdy_i = 0 with continuous requests → exactly 2 acks, then rd_ack_o = 0. rd_val_o holds the first word. Raising rd_rdy_i resumes in order with no loss or duplication.
- Edge lengths: len 0 → no busy_o, no done_o. len 256 from base 0x10 → 256 writes, address wraps to 0x0F, single done_o. start_i during FILL is ignored.
- Reset: assert rstn low mid-burst with one read inflight → all outputs at reset values immediately. After release, no stale rd_val_o and no done_o.

Source files
------------

// File: rtl/mc_ram_1p_ctrl_pkg.sv
// mc_ram_1p_ctrl_pkg: shared widths and burst FSM encoding for the MC RAM controller.
package mc_ram_1p_ctrl_pkg;
   localparam int WORD_W = 20;
   localparam int ADDR_W = 8;
   typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_e;
endpackage

// File: rtl/mc_rd_fifo2.sv
// mc_rd_fifo2: 2-entry synchronous FIFO buffering RAM read responses.
module mc_rd_fifo2
   import mc_ram_1p_ctrl_pkg::*;
#(
   parameter int W = WORD_W
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         push_i,
   input  logic [W-1:0] dat_i,
   input  logic         pop_i,
   output logic         val_o,
   output logic [W-1:0] dat_o,
   output logic [1:0]   cnt_o
);
   logic [W-1:0] mem_q [2];
   logic         wp_q, rp_q;
   logic [1:0]   cnt_q;
   logic         do_push, do_pop;
   assign do_pop  = pop_i & (cnt_q != 2'd0);
   assign do_push = push_i & ((cnt_q != 2'd2) | do_pop);
   assign val_o   = cnt_q != 2'd0;
   assign dat_o   = mem_q[rp_q];
   assign cnt_o   = cnt_q;
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wp_q     <= 1'b0;
         rp_q     <= 1'b0;
         cnt_q    <= 2'd0;
      end else begin
         if (do_push) begin
            mem_q[wp_q] <= dat_i;
            wp_q        <= ~wp_q;
         end
         if (do_pop) rp_q <= ~rp_q;
         cnt_q <= cnt_q + 2'(do_push) - 2'(do_pop);
      end
   end
endmodule

// File: rtl/mc_ram_1p_ctrl.sv
// mc_ram_1p_ctrl: arbitrates a burst-write stream and a random-read stream onto one
// single-port SRAM, one access per cycle, with a 2-deep read response buffer.
module mc_ram_1p_ctrl
   import mc_ram_1p_ctrl_pkg::*;
#(
   parameter int Word_Width = WORD_W,
   parameter int Addr_Width = ADDR_W
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  start_i,
   input  logic [Addr_Width-1:0] base_i,
   input  logic [Addr_Width:0]   len_i,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic                  wr_val_i,
   input  logic [Word_Width-1:0] wr_dat_i,
   output logic                  wr_rdy_o,
   input  logic                  rd_req_i,
   input  logic [Addr_Width-1:0] rd_addr_i,
   output logic                  rd_ack_o,
   output logic                  rd_val_o,
   output logic [Word_Width-1:0] rd_dat_o,
   input  logic                  rd_rdy_i,
   output logic                  ram_cen_o,
   output logic                  ram_oen_o,
   output logic                  ram_wen_o,
   output logic [Addr_Width-1:0] ram_addr_o,
   output logic [Word_Width-1:0] ram_dat_o,
   input  logic [Word_Width-1:0] ram_dat_i
);
   state_e                state_q, state_d;
   logic [Addr_Width-1:0] waddr_q, waddr_d;
   logic [Addr_Width:0]   rem_q, rem_d;
   logic                  done_q, done_d, prio_q, prio_d, infl_q;
   logic                  wr_cand, rd_cand, wr_gnt, rd_gnt, credit, pop;
   logic [1:0]            cnt;
   // Credit counts buffered plus inflight reads, net of this cycle's pop.
   assign pop     = rd_val_o & rd_rdy_i;
   assign credit  = ({1'b0, cnt} + {2'b0, infl_q}) < (3'd2 + {2'b0, pop});
   assign wr_cand = (state_q == FILL) & wr_val_i;
   assign rd_cand = rd_req_i & credit;
   assign wr_gnt  = wr_cand & (~rd_cand | ~prio_q);
   assign rd_gnt  = rd_cand & (~wr_cand | prio_q);
   always_comb begin
      state_d = state_q;
      waddr_d = waddr_q;
      rem_d   = rem_q;
      done_d  = 1'b0;
      prio_d  = prio_q ^ (wr_cand & rd_cand);
      if (state_q == IDLE) begin
         if (start_i && len_i != '0) begin
            state_d = FILL;
            waddr_d = base_i;
            rem_d   = len_i;
         end
      end else if (wr_gnt) begin
         waddr_d = waddr_q + Addr_Width'(1);
         rem_d   = rem_q - (Addr_Width+1)'(1);
         if (rem_q == (Addr_Width+1)'(1)) begin
            state_d = IDLE;
            done_d  = 1'b1;
         end
      end
   end
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         waddr_q <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         prio_q  <= 1'b0;
         infl_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         waddr_q <= waddr_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         prio_q  <= prio_d;
         infl_q  <= rd_gnt;
      end
   end
   mc_rd_fifo2 #(.W(Word_Width)) u_fifo (
      .clk    (clk),
      .rstn   (rstn),
      .push_i (infl_q),
      .dat_i  (ram_dat_i),
      .pop_i  (pop),
      .val_o  (rd_val_o),
      .dat_o  (rd_dat_o),
      .cnt_o  (cnt)
   );
   // Outputs are masked by rstn so the pins sit at idle values while reset is held.
   assign busy_o     = state_q == FILL;
   assign done_o     = done_q;
   assign wr_rdy_o   = rstn & wr_gnt;
   assign rd_ack_o   = rstn & rd_gnt;
   assign ram_cen_o  = ~(rstn & (wr_gnt | rd_gnt));
   assign ram_wen_o  = ~(rstn & wr_gnt);
   assign ram_oen_o  = 1'b0;
   assign ram_addr_o = !rstn ? '0 : wr_gnt ? waddr_q : rd_addr_i;
   assign ram_dat_o  = rstn ? wr_dat_i : '0;
endmodule

// File: tb/tb_mc_ram_1p_ctrl.sv
// tb_mc_ram_1p_ctrl: table vectors, directed corner sequences and random traffic
// against a transaction-level model of the controller plus an SRAM stub.
module tb_mc_ram_1p_ctrl;
   logic        clk = 1'b0;
   logic        rstn;
   logic        start_i, busy_o, done_o, wr_val_i, wr_rdy_o, rd_req_i, rd_ack_o, rd_val_o, rd_rdy_i;
   logic [7:0]  base_i, rd_addr_i, ram_addr_o;
   logic [8:0]  len_i;
   logic [19:0] wr_dat_i, rd_dat_o, ram_dat_o, ram_rd;
   logic        ram_cen_o, ram_oen_o, ram_wen_o;
   mc_ram_1p_ctrl dut (
      .clk(clk), .rstn(rstn), .start_i(start_i), .base_i(base_i), .len_i(len_i),
      .busy_o(busy_o), .done_o(done_o), .wr_val_i(wr_val_i), .wr_dat_i(wr_dat_i),
      .wr_rdy_o(wr_rdy_o), .rd_req_i(rd_req_i), .rd_addr_i(rd_addr_i), .rd_ack_o(rd_ack_o),
      .rd_val_o(rd_val_o), .rd_dat_o(rd_dat_o), .rd_rdy_i(rd_rdy_i), .ram_cen_o(ram_cen_o),
      .ram_oen_o(ram_oen_o), .ram_wen_o(ram_wen_o), .ram_addr_o(ram_addr_o),
      .ram_dat_o(ram_dat_o), .ram_dat_i(ram_rd)
   );
   always #5 clk = ~clk;
   function automatic logic [19:0] seed_word(input int a);
      return 20'(a * 977 + 3);
   endfunction
   logic [19:0] ram [256];
   bit          ram_filled;
   always @(posedge clk) begin
      if (!ram_filled) begin
         for (int i = 0; i < 256; i++) ram[i] <= seed_word(i);
         ram_filled <= 1'b1;
      end else if (!ram_cen_o) begin
         if (!ram_wen_o) ram[ram_addr_o] <= ram_dat_o;
         else ram_rd <= ram[ram_addr_o];
      end
   end
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int n_cmp = 0, n_fail = 0;
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask
   // Model: a burst is an address/remaining pair, a read is a queued word due two cycles later.
   typedef struct {logic [19:0] d; int t;} rsp_t;
   rsp_t        q[$];
   logic [19:0] ref_mem [256];
   logic [7:0]  m_addr;
   int          m_rem;
   bit          m_busy, m_prio, m_done;
   task automatic model_step();
      bit ev, pop, wc, rc, ew, er, ob;
      if (!rstn) begin
         chk("rst_busy", busy_o, 0);      chk("rst_done", done_o, 0);
         chk("rst_wr_rdy", wr_rdy_o, 0);  chk("rst_rd_ack", rd_ack_o, 0);
         chk("rst_rd_val", rd_val_o, 0);  chk("rst_rd_dat", rd_dat_o, 0);
         chk("rst_cen", ram_cen_o, 1);    chk("rst_wen", ram_wen_o, 1);
         chk("rst_oen", ram_oen_o, 0);    chk("rst_addr", ram_addr_o, 0);
         chk("rst_wdat", ram_dat_o, 0);
         m_busy = 0; m_prio = 0; m_done = 0; q.delete();
         return;
      end
      ev  = q.size() > 0 && q[0].t <= cyc;
      pop = ev && rd_rdy_i;
      wc  = m_busy && wr_val_i;
      rc  = rd_req_i && (q.size() - int'(pop) < 2);
      ew  = wc && (!rc || !m_prio);
      er  = rc && (!wc || m_prio);
      chk("wr_rdy", wr_rdy_o, ew);   chk("rd_ack", rd_ack_o, er);
      chk("busy", busy_o, m_busy);   chk("done", done_o, m_done);
      chk("rd_val", rd_val_o, ev);
      if (ev) chk("rd_dat", rd_dat_o, q[0].d);
      chk("cen", ram_cen_o, !(ew || er));
      chk("wen", ram_wen_o, !ew);
      chk("oen", ram_oen_o, 0);
      if (ew) begin
         chk("wr_addr", ram_addr_o, m_addr);
         chk("wr_dat", ram_dat_o, wr_dat_i);
      end
      if (er) chk("rd_addr", ram_addr_o, rd_addr_i);
      ob = m_busy;
      m_done = 0;
      if (pop) void'(q.pop_front());
      if (wc && rc) m_prio = !m_prio;
      if (ew) begin
         ref_mem[m_addr] = wr_dat_i;
         m_addr++;
         m_rem--;
         if (m_rem == 0) begin m_busy = 0; m_done = 1; end
      end
      if (er) q.push_back('{d: ref_mem[rd_addr_i], t: cyc + 2});
      if (!ob && start_i && len_i != 0) begin m_busy = 1; m_addr = base_i; m_rem = int'(len_i); end
   endtask
   task automatic sample(); @(negedge clk); model_step(); endtask
   task automatic nxt(); @(posedge clk); #1; endtask
   task automatic tick(); sample(); nxt(); endtask
   task automatic idle();
      start_i = 0; base_i = 0; len_i = 0; wr_val_i = 0; wr_dat_i = 0;
      rd_req_i = 0; rd_addr_i = 0; rd_rdy_i = 1;
   endtask
   typedef struct {
      logic st; logic [7:0] base; logic [8:0] len; logic wv; logic [19:0] wd;
      logic rq; logic [7:0] ra; logic rr;
      logic busy, done, wrdy, rack, rval; logic [19:0] rdat; logic [7:0] raddr;
   } vec_t;
   vec_t tbl [14];
   int   acks, beats, dones;
   logic [7:0] last;
   bit   fin;
   initial begin
      for (int i = 0; i < 256; i++) ref_mem[i] = seed_word(i);
      tbl[0]  = '{1, 8'hFE, 9'd4, 0, 0, 0, 8'h00, 1,  0, 0, 0, 0, 0, 0, 8'h00};
      tbl[1]  = '{0, 8'h00, 9'd0, 1, 1, 0, 8'h00, 1,  1, 0, 1, 0, 0, 0, 8'hFE};
      tbl[2]  = '{0, 8'h00, 9'd0, 1, 2, 0, 8'h00, 1,  1, 0, 1, 0, 0, 0, 8'hFF};
      tbl[3]  = '{0, 8'h00, 9'd0, 1, 3, 0, 8'h00, 1,  1, 0, 1, 0, 0, 0, 8'h00};
      tbl[4]  = '{0, 8'h00, 9'd0, 1, 4, 0, 8'h00, 1,  1, 0, 1, 0, 0, 0, 8'h01};
      tbl[5]  = '{0, 8'h00, 9'd0, 1, 5, 0, 8'h00, 1,  0, 1, 0, 0, 0, 0, 8'h00};
      tbl[6]  = '{0, 8'h00, 9'd0, 0, 0, 0, 8'h00, 1,  0, 0, 0, 0, 0, 0, 8'h00};
      tbl[7]  = '{0, 8'h00, 9'd0, 0, 0, 1, 8'hFE, 1,  0, 0, 0, 1, 0, 0, 8'hFE};
      tbl[8]  = '{0, 8'h00, 9'd0, 0, 0, 1, 8'hFF, 1,  0, 0, 0, 1, 0, 0, 8'hFF};
      tbl[9]  = '{0, 8'h00, 9'd0, 0, 0, 1, 8'h00, 1,  0, 0, 0, 1, 1, 1, 8'h00};
      tbl[10] = '{0, 8'h00, 9'd0, 0, 0, 1, 8'h01, 1,  0, 0, 0, 1, 1, 2, 8'h01};
      tbl[11] = '{0, 8'h00, 9'd0, 0, 0, 0, 8'h00, 1,  0, 0, 0, 0, 1, 3, 8'h00};
      tbl[12] = '{0, 8'h00, 9'd0, 0, 0, 0, 8'h00, 1,  0, 0, 0, 0, 1, 4, 8'h00};
      tbl[13] = '{0, 8'h00, 9'd0, 0, 0, 0, 8'h00, 1,  0, 0, 0, 0, 0, 0, 8'h00};
      rstn = 0;
      idle();
      repeat (3) tick();
      rstn = 1;
      for (int i = 0; i < 14; i++) begin
         start_i = tbl[i].st; base_i = tbl[i].base; len_i = tbl[i].len;
         wr_val_i = tbl[i].wv; wr_dat_i = tbl[i].wd; rd_req_i = tbl[i].rq;
         rd_addr_i = tbl[i].ra; rd_rdy_i = tbl[i].rr;
         sample();
         chk("tv_busy", busy_o, tbl[i].busy);  chk("tv_done", done_o, tbl[i].done);
         chk("tv_wr_rdy", wr_rdy_o, tbl[i].wrdy); chk("tv_rd_ack", rd_ack_o, tbl[i].rack);
         chk("tv_rd_val", rd_val_o, tbl[i].rval); chk("tv_ram_addr", ram_addr_o, tbl[i].raddr);
         if (tbl[i].rval) chk("tv_rd_dat", rd_dat_o, tbl[i].rdat);
         nxt();
      end
      idle(); start_i = 1; base_i = 8'h40; len_i = 9'd4;
      tick();
      start_i = 0; wr_val_i = 1; rd_req_i = 1; rd_addr_i = 8'h40;
      for (int i = 0; i < 8; i++) begin
         wr_dat_i = 20'($urandom);
         sample();
         chk("cont_w", wr_rdy_o, (i % 2) == 0);
         chk("cont_r", rd_ack_o, (i % 2) == 1);
         nxt();
      end
      idle(); repeat (3) tick();
      rd_req_i = 1; rd_rdy_i = 0; acks = 0;
      for (int i = 0; i < 6; i++) begin
         rd_addr_i = 8'($urandom);
         sample();
         acks += int'(rd_ack_o);
         if (i == 5) chk("bp_ack_low", rd_ack_o, 0);
         nxt();
      end
      chk("bp_acks", acks, 2);
      rd_req_i = 0; rd_rdy_i = 1;
      repeat (4) tick();
      idle(); start_i = 1; base_i = 8'h05; len_i = 9'd0;
      tick();
      start_i = 0;
      for (int i = 0; i < 3; i++) begin
         sample();
         chk("len0_busy", busy_o, 0);
         chk("len0_done", done_o, 0);
         nxt();
      end
      start_i = 1; base_i = 8'h10; len_i = 9'd256;
      tick();
      wr_val_i = 1; beats = 0; dones = 0; last = 0; fin = 0;
      for (int i = 0; i < 300 && !fin; i++) begin
         wr_dat_i = 20'($urandom); start_i = (i == 50); base_i = 8'h77; len_i = 9'd5;
         sample();
         if (wr_rdy_o) begin beats++; last = ram_addr_o; end
         dones += int'(done_o);
         if (!busy_o) fin = 1;
         nxt();
      end
      chk("len256_timeout", fin, 1);
      idle();
      for (int i = 0; i < 3; i++) begin
         sample();
         dones += int'(done_o);
         nxt();
      end
      chk("len256_beats", beats, 256);
      chk("len256_last", last, 8'h0F);
      chk("len256_dones", dones, 1);
      start_i = 1; base_i = 8'h20; len_i = 9'd8;
      tick();
      start_i = 0; wr_val_i = 1;
      repeat (2) tick();
      wr_val_i = 0; rd_req_i = 1; rd_addr_i = 8'h21;
      tick();
      rstn = 0; wr_val_i = 1; rd_req_i = 1; rd_addr_i = 8'h33;
      sample();
      chk("rst_mid_busy", busy_o, 0);
      chk("rst_mid_cen", ram_cen_o, 1);
      nxt();
      rstn = 1; idle();
      for (int i = 0; i < 4; i++) begin
         sample();
         chk("post_rst_val", rd_val_o, 0);
         chk("post_rst_done", done_o, 0);
         chk("post_rst_busy", busy_o, 0);
         nxt();
      end
      for (int i = 0; i < 2500; i++) begin
         start_i   = $urandom_range(0, 15) == 0;
         base_i    = 8'($urandom);
         len_i     = ($urandom_range(0, 9) == 0) ? 9'd0 : 9'($urandom_range(1, 12));
         wr_val_i  = $urandom_range(0, 9) < 7;
         wr_dat_i  = 20'($urandom);
         rd_req_i  = $urandom_range(0, 1) == 1;
         rd_addr_i = 8'($urandom);
         rd_rdy_i  = $urandom_range(0, 9) < 6;
         rstn      = (i != 1200);
         tick();
      end
      rstn = 1; idle();
      repeat (6) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
